// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory access unit: funct3 codes, response
// error codes, FSM state encoding and request legality helpers.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Unsigned widths are only meaningful for loads.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_illegal = 1'b0;
      F3_BU, F3_HU:     f3_illegal = we;
      default:          f3_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: misaligned = off[0];
      F3_W:        misaligned = (off != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data/selector placement and
// load data extraction with sign or zero extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] datain,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // Store side: replicate data into every lane, let the selector pick.
  always_comb begin
    sel    = 4'b0000;
    datain = 32'h0;
    case (funct3)
      F3_B: begin
        sel    = 4'b0001 << offset;
        datain = {4{wdata[7:0]}};
      end
      F3_H: begin
        sel    = offset[1] ? 4'b1100 : 4'b0011;
        datain = {2{wdata[15:0]}};
      end
      F3_W: begin
        sel    = 4'b1111;
        datain = wdata;
      end
      default: ;
    endcase
  end

  // Load side: bring the addressed bytes down to bit 0 and extend.
  always_comb begin
    rdata_ext = 32'h0;
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata_ext = rdata;
      F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
      F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for a word-organised memory.
// IDLE accepts and validates, ACCESS drives the strobes, RESP pulses the
// response for one cycle. Every output is a register.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit         WORD_ADDR  = 1'b0,
  parameter bit         USE_MEMSIG = 1'b1,
  parameter logic [3:0] TIMEOUT    = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_addy,
  output logic [31:0] mem_datain,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [3:0]  mem_byte_selector,
  input  logic [31:0] mem_dataout,
  input  logic        mem_memsig
);

  state_t      state;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;
  logic [3:0]  wait_cnt;

  logic [2:0]  aln_f3;
  logic [1:0]  aln_off;
  logic [3:0]  aln_sel;
  logic [31:0] aln_datain;
  logic [31:0] aln_rext;

  // Store lanes are computed from the live request at acceptance; load
  // extraction uses the latched request while waiting on the memory.
  assign aln_f3  = (state == ST_IDLE) ? req_funct3    : lat_f3;
  assign aln_off = (state == ST_IDLE) ? req_addr[1:0] : lat_off;

  mem_lane_align u_align (
    .funct3    (aln_f3),
    .offset    (aln_off),
    .wdata     (req_wdata),
    .rdata     (mem_dataout),
    .sel       (aln_sel),
    .datain    (aln_datain),
    .rdata_ext (aln_rext)
  );

  // FSM, request latch, wait counter and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      lat_we            <= 1'b0;
      lat_f3            <= 3'b000;
      lat_off           <= 2'b00;
      wait_cnt          <= 4'd0;
      req_ready         <= 1'b1;
      resp_valid        <= 1'b0;
      resp_rdata        <= 32'h0;
      resp_err          <= ERR_OK;
      mem_addy          <= 32'h0;
      mem_datain        <= 32'h0;
      mem_wen           <= 1'b0;
      mem_ren           <= 1'b0;
      mem_byte_selector <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_off   <= req_addr[1:0];
            req_ready <= 1'b0;
            if (f3_illegal(req_we, req_funct3)) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= ERR_ILLEGAL;
              resp_rdata <= 32'h0;
            end else if (misaligned(req_funct3, req_addr[1:0])) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= ERR_MISALIGN;
              resp_rdata <= 32'h0;
            end else begin
              state    <= ST_ACCESS;
              wait_cnt <= 4'd1;
              mem_addy <= WORD_ADDR ? {2'b00, req_addr[31:2]} : req_addr;
              if (req_we) begin
                mem_wen           <= 1'b1;
                mem_byte_selector <= aln_sel;
                mem_datain        <= aln_datain;
              end else begin
                mem_ren           <= 1'b1;
                mem_byte_selector <= 4'b0000;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (lat_we) begin
            // Stores hold the write strobe for exactly one cycle.
            mem_wen           <= 1'b0;
            mem_byte_selector <= 4'b0000;
            state             <= ST_RESP;
            resp_valid        <= 1'b1;
            resp_err          <= ERR_OK;
            resp_rdata        <= 32'h0;
          end else if (mem_memsig || !USE_MEMSIG) begin
            mem_ren    <= 1'b0;
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= ERR_OK;
            resp_rdata <= aln_rext;
          end else if (wait_cnt >= TIMEOUT) begin
            mem_ren    <= 1'b0;
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= ERR_TIMEOUT;
            resp_rdata <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= ERR_OK;
          resp_rdata <= 32'h0;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          mem_wen   <= 1'b0;
          mem_ren   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with default parameters
// (byte addressing, memsig handshake, TIMEOUT=15).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] mem_addy;
  logic [31:0] mem_datain;
  logic        mem_wen;
  logic        mem_ren;
  logic [3:0]  mem_byte_selector;
  logic [31:0] mem_dataout;
  logic        mem_memsig;

  int checks = 0;
  int errors = 0;

  // Memory stand-in: fixed read word, ack after ack_wait full ren cycles.
  logic [31:0] rd_word = 32'h0;
  logic        ack_en  = 1'b1;
  int          ack_wait = 0;
  int          ren_cnt  = 0;

  assign mem_dataout = rd_word;
  assign mem_memsig  = ack_en && mem_ren && (ren_cnt >= ack_wait);

  always @(posedge clk) ren_cnt <= mem_ren ? ren_cnt + 1 : 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_funct3        (req_funct3),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_err          (resp_err),
    .mem_addy          (mem_addy),
    .mem_datain        (mem_datain),
    .mem_wen           (mem_wen),
    .mem_ren           (mem_ren),
    .mem_byte_selector (mem_byte_selector),
    .mem_dataout       (mem_dataout),
    .mem_memsig        (mem_memsig)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and check everything observed until the response.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int e_lat, input int e_wen, input int e_ren,
                     input logic [3:0] e_sel, input logic [31:0] e_datain,
                     input logic [31:0] e_addy, input logic [1:0] e_err,
                     input logic [31:0] e_rdata);
    int lat, wen_cyc, ren_cyc, both, after;
    logic [3:0]  sel;
    logic [31:0] datain, addy, rdata;
    logic [1:0]  err;
    lat = -1; wen_cyc = 0; ren_cyc = 0; both = 0;
    sel = 4'hx; datain = 32'hx; addy = 32'hx; rdata = 32'hx; err = 2'bxx;
    @(negedge clk);
    chk({tag, ".ready"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_wen && mem_ren) both++;
      if (mem_wen) begin
        wen_cyc++; sel = mem_byte_selector; datain = mem_datain; addy = mem_addy;
      end
      if (mem_ren) begin
        ren_cyc++; sel = mem_byte_selector; addy = mem_addy;
      end
      if (resp_valid) begin
        lat = k; err = resp_err; rdata = resp_rdata;
      end
    end
    @(negedge clk);
    after = int'(resp_valid) + int'(mem_wen) + int'(mem_ren);
    chk({tag, ".lat"}, lat, e_lat);
    chk({tag, ".err"}, {30'h0, err}, {30'h0, e_err});
    chk({tag, ".rdata"}, rdata, e_rdata);
    chk({tag, ".wen_cyc"}, wen_cyc, e_wen);
    chk({tag, ".ren_cyc"}, ren_cyc, e_ren);
    chk({tag, ".both"}, both, 0);
    chk({tag, ".after"}, after, 0);
    if (e_wen + e_ren > 0) begin
      chk({tag, ".sel"}, {28'h0, sel}, {28'h0, e_sel});
      chk({tag, ".addy"}, addy, e_addy);
    end
    if (e_wen > 0) chk({tag, ".datain"}, datain, e_datain);
  endtask

  initial begin
    logic [5:0] wen_vec, rv_vec;
    int pulses;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst.ready", {31'h0, req_ready}, 32'd1);
    chk("rst.strobes", {28'h0, mem_wen, mem_ren, resp_valid, 1'b0}, 32'h0);
    chk("rst.sel", {28'h0, mem_byte_selector}, 32'h0);
    chk("rst.addy", mem_addy, 32'h0);
    chk("rst.datain", mem_datain, 32'h0);
    chk("rst.resp", {resp_rdata[29:0], resp_err}, 32'h0);
    rst = 1'b0;

    // Stores: lane placement and one-cycle write strobe.
    txn("sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 1, 0, 4'b1111, 32'hDEADBEEF, 32'h10, 2'b00, 32'h0);
    txn("sb", 1'b1, 3'b000, 32'h13, 32'h000000A5, 2, 1, 0, 4'b1000, 32'hA5A5A5A5, 32'h13, 2'b00, 32'h0);
    txn("sh", 1'b1, 3'b001, 32'h12, 32'hCAFE1234, 2, 1, 0, 4'b1100, 32'h12341234, 32'h12, 2'b00, 32'h0);
    txn("sw_top", 1'b1, 3'b010, 32'hFFFFFFFC, 32'h01020304, 2, 1, 0, 4'b1111, 32'h01020304, 32'hFFFFFFFC, 2'b00, 32'h0);

    // Loads, memsig in the first ACCESS cycle.
    ack_en = 1'b1; ack_wait = 0;
    rd_word = 32'hA5000000;
    txn("lb", 1'b0, 3'b000, 32'h13, 32'h0, 2, 0, 1, 4'b0000, 32'h0, 32'h13, 2'b00, 32'hFFFFFFA5);
    txn("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 2, 0, 1, 4'b0000, 32'h0, 32'h13, 2'b00, 32'h000000A5);
    rd_word = 32'h80017FFF;
    txn("lh", 1'b0, 3'b001, 32'h12, 32'h0, 2, 0, 1, 4'b0000, 32'h0, 32'h12, 2'b00, 32'hFFFF8001);
    txn("lhu", 1'b0, 3'b101, 32'h12, 32'h0, 2, 0, 1, 4'b0000, 32'h0, 32'h12, 2'b00, 32'h00008001);
    txn("lh_lo", 1'b0, 3'b001, 32'h10, 32'h0, 2, 0, 1, 4'b0000, 32'h0, 32'h10, 2'b00, 32'h00007FFF);
    txn("lw", 1'b0, 3'b010, 32'h10, 32'h0, 2, 0, 1, 4'b0000, 32'h0, 32'h10, 2'b00, 32'h80017FFF);

    // Errors: no strobes, response one cycle after acceptance.
    txn("lh_mis", 1'b0, 3'b001, 32'h11, 32'h0, 1, 0, 0, 4'b0000, 32'h0, 32'h0, 2'b01, 32'h0);
    txn("sw_mis", 1'b1, 3'b010, 32'h12, 32'h55, 1, 0, 0, 4'b0000, 32'h0, 32'h0, 2'b01, 32'h0);
    txn("f3_011", 1'b0, 3'b011, 32'h11, 32'h0, 1, 0, 0, 4'b0000, 32'h0, 32'h0, 2'b11, 32'h0);
    txn("st_100", 1'b1, 3'b100, 32'h10, 32'h77, 1, 0, 0, 4'b0000, 32'h0, 32'h0, 2'b11, 32'h0);

    // Timeout after 15 ACCESS cycles, then a late memsig on cycle 3.
    ack_en = 1'b0; rd_word = 32'h12345678;
    txn("tmo", 1'b0, 3'b010, 32'h20, 32'h0, 16, 0, 15, 4'b0000, 32'h0, 32'h20, 2'b10, 32'h0);
    ack_en = 1'b1; ack_wait = 2;
    txn("late", 1'b0, 3'b010, 32'h20, 32'h0, 4, 0, 3, 4'b0000, 32'h0, 32'h20, 2'b00, 32'h12345678);
    ack_wait = 0;

    // req_valid held: next store accepted only after RESP (every 3 cycles).
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h1;
    wen_vec = '0; rv_vec = '0;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      wen_vec[k] = mem_wen;
      rv_vec[k]  = resp_valid;
    end
    req_valid = 1'b0;
    chk("hold.wen", {26'h0, wen_vec}, 32'b001001);
    chk("hold.resp", {26'h0, rv_vec}, 32'b010010);
    repeat (4) @(negedge clk);

    // Reset in the middle of a load ACCESS discards it.
    ack_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstld.pre_ren", {31'h0, mem_ren}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstld.ren", {31'h0, mem_ren}, 32'd0);
    chk("rstld.resp", {31'h0, resp_valid}, 32'd0);
    chk("rstld.ready", {31'h0, req_ready}, 32'd1);
    rst = 1'b0; ack_en = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      pulses += int'(resp_valid) + int'(mem_ren);
    end
    chk("rstld.quiet", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
